// File: rtl/branch_target_table.sv
// Branch target table: DEPTH entries of {valid, target}, cleared one entry per
// cycle after reset, then serving 1-cycle-latency lookups with write-first bypass.
module branch_target_table #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_ack,
    output logic              rd_hit,
    output logic [ADDR_W-1:0] rd_target,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [ADDR_W-1:0] wr_target,
    input  logic              inv_en,
    output logic              busy
);
    localparam int DEPTH = 2**IDX_W;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic              hit;
        logic [ADDR_W-1:0] target;
    } rd_rsp_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              cnt_q, cnt_d;
    logic                          run;
    logic [DEPTH-1:0]              ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0]  ent_tgt;
    rd_rsp_t                       rsp;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The clear counter wraps to 0 exactly on the INIT->RUN edge and then idles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            INIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {IDX_W{1'b1}})
                    state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;
            end
            default: state_d = INIT;
        endcase
    end

    assign run = (state_q == RUN);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic clr, wr, inv;
        assign clr = !run && (cnt_q == IDX_W'(i));
        assign wr  = run && wr_en && (wr_index == IDX_W'(i));
        assign inv = run && inv_en && !wr_en && (wr_index == IDX_W'(i));

        always_ff @(posedge Clk) begin
            if (Reset) begin
                ent_vld[i] <= 1'b0;
            end else if (clr) begin
                ent_vld[i] <= 1'b0;
                ent_tgt[i] <= '0;
            end else if (wr) begin
                ent_vld[i] <= 1'b1;
                ent_tgt[i] <= wr_target;
            end else if (inv) begin
                ent_vld[i] <= 1'b0;
            end
        end
    end

    // Same-cycle write (or invalidate) to the looked-up index is forwarded.
    always_comb begin
        rsp.hit    = ent_vld[rd_index];
        rsp.target = ent_vld[rd_index] ? ent_tgt[rd_index] : '0;
        if (wr_en && (wr_index == rd_index)) begin
            rsp.hit    = 1'b1;
            rsp.target = wr_target;
        end else if (inv_en && (wr_index == rd_index)) begin
            rsp.hit    = 1'b0;
            rsp.target = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ack    <= 1'b0;
            rd_hit    <= 1'b0;
            rd_target <= '0;
        end else if (run && rd_en) begin
            rd_ack    <= 1'b1;
            rd_hit    <= rsp.hit;
            rd_target <= rsp.target;
        end else begin
            rd_ack    <= 1'b0;
            rd_hit    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench for branch_target_table with a per-cycle reference model.
module tb_branch_target_table;
    localparam int IDX_W  = 4;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 16;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              rd_en = 1'b0;
    logic [IDX_W-1:0]  rd_index = '0;
    logic              rd_ack, rd_hit;
    logic [ADDR_W-1:0] rd_target;
    logic              wr_en = 1'b0;
    logic [IDX_W-1:0]  wr_index = '0;
    logic [ADDR_W-1:0] wr_target = '0;
    logic              inv_en = 1'b0;
    logic              busy;

    int checks = 0;
    int failures = 0;

    branch_target_table #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .rd_en(rd_en), .rd_index(rd_index),
        .rd_ack(rd_ack), .rd_hit(rd_hit), .rd_target(rd_target),
        .wr_en(wr_en), .wr_index(wr_index), .wr_target(wr_target),
        .inv_en(inv_en), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table contents plus remaining clear cycles.
    bit  m_vld [DEPTH];
    int  m_tgt [DEPTH];
    int  init_left = 0;
    bit  started = 0;
    bit  e_ack = 0, e_hit = 0;
    int  e_tgt = 0;

    always @(posedge Clk) begin
        if (Reset) begin
            started   = 1;
            init_left = DEPTH;
            e_ack = 0; e_hit = 0; e_tgt = 0;
            for (int i = 0; i < DEPTH; i++) begin m_vld[i] = 0; m_tgt[i] = 0; end
        end else if (started && init_left > 0) begin
            init_left--;
            e_ack = 0; e_hit = 0;
        end else if (started) begin
            if (rd_en) begin
                e_ack = 1;
                if (wr_en && wr_index == rd_index) begin
                    e_hit = 1; e_tgt = int'(wr_target);
                end else if (inv_en && wr_index == rd_index) begin
                    e_hit = 0; e_tgt = 0;
                end else begin
                    e_hit = m_vld[rd_index];
                    e_tgt = m_vld[rd_index] ? m_tgt[rd_index] : 0;
                end
            end else begin
                e_ack = 0; e_hit = 0;
            end
            if (wr_en) begin
                m_vld[wr_index] = 1; m_tgt[wr_index] = int'(wr_target);
            end else if (inv_en) begin
                m_vld[wr_index] = 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (started) begin
            chk("busy", 32'(busy), 32'(init_left > 0));
            chk("rd_ack", 32'(rd_ack), 32'(e_ack));
            chk("rd_hit", 32'(rd_hit), 32'(e_hit));
            chk("rd_target", 32'(rd_target), 32'(e_tgt));
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic do_reset();
        Reset = 1'b1; rd_en = 0; wr_en = 0; inv_en = 0;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic count_busy(input string name, input bit junk_wr);
        int n = 0;
        if (junk_wr) begin wr_en = 1; wr_index = 4'd2; wr_target = 9'd77; inv_en = 0; end
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge Clk);
        end
        wr_en = 0;
        chk(name, 32'(n), 32'd16);
    endtask

    task automatic expect_rd(input string name, input bit h, input int t);
        chk({name, "_ack"}, 32'(rd_ack), 32'd1);
        chk({name, "_hit"}, 32'(rd_hit), 32'(h));
        chk({name, "_tgt"}, 32'(rd_target), 32'(t));
    endtask

    task automatic rd(input int idx, input bit h, input int t, input string name);
        rd_en = 1; rd_index = 4'(idx);
        @(negedge Clk);
        rd_en = 0;
        expect_rd(name, h, t);
    endtask

    task automatic wr(input int idx, input int t);
        wr_en = 1; wr_index = 4'(idx); wr_target = 9'(t);
        @(negedge Clk);
        wr_en = 0;
    endtask

    task automatic inv(input int idx);
        inv_en = 1; wr_index = 4'(idx);
        @(negedge Clk);
        inv_en = 0;
    endtask

    int tv [13] = '{27, 34, 39, 53, 58, 61, 66, 112, 123, 128, 131, 136, 171};

    initial begin
        @(negedge Clk);
        do_reset();
        chk("reset_rd_ack", 32'(rd_ack), 32'd0);
        chk("reset_rd_target", 32'(rd_target), 32'd0);
        count_busy("busy_len_first", 0);
        rd(5, 0, 0, "rd5_after_init");

        wr(3, 53);
        rd(3, 1, 53, "rd3");

        wr_en = 1; wr_index = 4'd7; wr_target = 9'd112; rd_en = 1; rd_index = 4'd7;
        @(negedge Clk);
        wr_en = 0; rd_en = 0;
        expect_rd("bypass7", 1, 112);

        wr(12, 171);
        inv(12);
        rd(12, 0, 0, "rd12_inv");
        wr_en = 1; inv_en = 1; wr_index = 4'd12; wr_target = 9'd136;
        @(negedge Clk);
        wr_en = 0; inv_en = 0;
        rd(12, 1, 136, "rd12_wr_inv");
        @(negedge Clk);
        chk("idle_ack", 32'(rd_ack), 32'd0);
        chk("idle_hit", 32'(rd_hit), 32'd0);
        chk("idle_tgt_hold", 32'(rd_target), 32'd136);

        inv_en = 1; wr_index = 4'd3; rd_en = 1; rd_index = 4'd3;
        @(negedge Clk);
        inv_en = 0; rd_en = 0;
        expect_rd("rd3_inv_bypass", 0, 0);
        rd(3, 0, 0, "rd3_after_inv");

        for (int i = 0; i < 13; i++) wr(i, tv[i]);
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                if (i - 1 < 13) expect_rd($sformatf("b2b%0d", i - 1), 1, tv[i - 1]);
                else            expect_rd($sformatf("b2b%0d", i - 1), 0, 0);
            end
            if (i < 16) begin
                rd_en = 1; rd_index = 4'(i);
                @(negedge Clk);
            end else begin
                rd_en = 0;
            end
        end

        do_reset();
        repeat (8) @(negedge Clk);
        do_reset();
        count_busy("busy_len_midinit", 1);
        rd(2, 0, 0, "rd2_wr_during_busy");
        wr(1, 34);
        rd(1, 1, 34, "rd1_programmed");
        do_reset();
        count_busy("busy_len_midrun", 0);
        rd(1, 0, 0, "rd1_after_reset");
        rd(12, 0, 0, "rd12_after_reset");

        @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_target_table.md
BRANCH_TARGET_TABLE -- requirements
Module: branch_target_table

Interface
REQ-001 SHALL have parameter IDX_W, default 4, index width; table depth DEPTH = 2**IDX_W entries.
REQ-002 SHALL have parameter ADDR_W, default 9, jump-target width in bits.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rd_en  input  1  lookup request.
REQ-006 SHALL have port rd_index  input  IDX_W  entry to look up.
REQ-007 SHALL have port rd_ack  output  1  lookup response strobe.
REQ-008 SHALL have port rd_hit  output  1  looked-up entry was valid.
REQ-009 SHALL have port rd_target  output  ADDR_W  looked-up jump target.
REQ-010 SHALL have port wr_en  input  1  program-entry request.
REQ-011 SHALL have port wr_index  input  IDX_W  entry to program.
REQ-012 SHALL have port wr_target  input  ADDR_W  target value to store.
REQ-013 SHALL have port inv_en  input  1  invalidate entry selected by wr_index.
REQ-014 SHALL have port busy  output  1  table is initialising; requests are ignored.

Function
REQ-015 SHALL hold DEPTH entries, each made of an ADDR_W target field and a 1-bit valid flag.
REQ-016 SHALL implement a two-state FSM, INIT and RUN.
REQ-017 In INIT, SHALL clear one entry per cycle (target=0, valid=0), starting at index 0 and counting upward.
REQ-018 SHALL go from INIT to RUN in the cycle after index DEPTH-1 is cleared, so INIT lasts exactly DEPTH cycles.
REQ-019 SHALL drive busy=1 in INIT and busy=0 in RUN.
REQ-020 In INIT, SHALL ignore rd_en, wr_en and inv_en, and SHALL hold rd_ack=0.
REQ-021 In RUN, when rd_en=1 at edge N, SHALL drive rd_ack=1 for exactly one cycle after edge N (1-cycle latency).
REQ-022 With that rd_ack, rd_hit SHALL equal the valid flag of rd_index, and rd_target SHALL equal the stored target if the entry is valid, else 0.
REQ-023 When rd_ack=0, SHALL hold rd_hit=0 and rd_target at its last value.
REQ-024 In RUN, wr_en=1 SHALL store wr_target into wr_index and set its valid flag; the new value is visible to a read issued in the following cycle.
REQ-025 In RUN, inv_en=1 with wr_en=0 SHALL clear the valid flag of wr_index and SHALL leave its target field unchanged.
REQ-026 When wr_en and inv_en are both 1, SHALL let the write win and set the entry valid.
REQ-027 When rd_en and wr_en target the same index in the same cycle, SHALL return the newly written value with rd_hit=1 (write-first bypass).
REQ-028 When rd_en and inv_en target the same index in the same cycle (wr_en=0), SHALL return rd_hit=0 and rd_target=0.
REQ-029 SHALL let back-to-back reads issue every cycle, giving one rd_ack per rd_en.
REQ-030 SHALL wrap the INIT counter only via the transition to RUN; the counter SHALL never re-clear entries while in RUN.

Reset
REQ-031 Reset=1 at an edge SHALL force the FSM to INIT, the INIT counter to 0, rd_ack=0, rd_hit=0, rd_target=0 and busy=1.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL restart the full DEPTH-cycle clear; entries programmed before reset SHALL read invalid afterwards.
REQ-033 While Reset=1, SHALL not apply any write or invalidate.

Verification
REQ-034 Reset for 1 cycle, release -> busy=1 for exactly 16 cycles, then 0; a read of index 5 then gives rd_ack=1, rd_hit=0, rd_target=0.
REQ-035 In RUN, write index 3 = 53, then read index 3 in the next cycle -> one cycle later rd_ack=1, rd_hit=1, rd_target=53.
REQ-036 Same cycle: wr_en index 7 = 112 and rd_en index 7 -> next cycle rd_hit=1, rd_target=112.
REQ-037 Program index 12 = 171, then inv_en index 12, then read index 12 -> rd_hit=0, rd_target=0; then wr_en and inv_en together on index 12 with 136, then read -> rd_hit=1, rd_target=136.
REQ-038 Program indices 0..12 with 27,34,39,53,58,61,66,112,123,128,131,136,171, then read 0..15 on consecutive cycles -> 16 consecutive rd_ack pulses, matching targets with rd_hit=1 for 0..12, rd_hit=0 and rd_target=0 for 13..15.
REQ-039 Assert Reset at INIT cycle 8 and again after programming index 1 = 34 -> INIT restarts for a full 16 cycles; index 1 then reads rd_hit=0; wr_en during busy=1 leaves the table unchanged.
